// File: rtl/agc_accumulator_mc_pkg.sv
// Shared constants and helpers for the multi-channel AGC loop integrator.
package agc_accumulator_mc_pkg;

  // Active level of the asynchronous reset input.
  localparam logic RST_VAL = 1'b0;

  // Width of the runtime right-shift field applied to error samples.
  localparam int SHIFT_W = 4;

  // Channel index width; a single-channel build still carries a 1-bit index.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/agc_accumulator_mc_if.sv
// Sample-in / gain-out bus of the AGC integrator.
// The master side drives error samples, the slave side returns gain words.
interface agc_accumulator_mc_if
  import agc_accumulator_mc_pkg::*;
#(
  parameter int CH_W  = 2,
  parameter int EPS_W = 32,
  parameter int OUT_W = 16
);

  logic               valid_i;
  logic [CH_W-1:0]    ch_i;
  logic [EPS_W-1:0]   eps_i;
  logic [SHIFT_W-1:0] shift_i;
  logic               freeze_i;
  logic               clear_i;

  logic               valid_o;
  logic [CH_W-1:0]    ch_o;
  logic [OUT_W-1:0]   c_o;
  logic               sat_hi_o;
  logic               sat_lo_o;
  logic               ch_err_o;

  modport master (
    output valid_i, ch_i, eps_i, shift_i, freeze_i, clear_i,
    input  valid_o, ch_o, c_o, sat_hi_o, sat_lo_o, ch_err_o
  );

  modport slave (
    input  valid_i, ch_i, eps_i, shift_i, freeze_i, clear_i,
    output valid_o, ch_o, c_o, sat_hi_o, sat_lo_o, ch_err_o
  );

endinterface

// File: rtl/agc_accumulator_mc_sat_add.sv
// Combinational scale-and-accumulate with clamping to [0, 2^(ACC_W-1)-1].
// The accumulator never goes negative, so the lower clamp is zero, not the
// most negative value.
module agc_sat_add
  import agc_accumulator_mc_pkg::*;
#(
  parameter int EPS_W = 32,
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [EPS_W-1:0]   eps_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [ACC_W-1:0]   sum_o,
  output logic               sat_hi_o,
  output logic               sat_lo_o
);

  // Two guard bits above the wider operand keep the sum exact.
  localparam int SUM_W = ((EPS_W > ACC_W) ? EPS_W : ACC_W) + 2;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  logic signed [EPS_W-1:0] scaled;
  logic signed [SUM_W-1:0] sum_w;
  logic                    neg;
  logic                    over;

  // Shift, sign-extend, add, then clamp into the non-negative range.
  always_comb begin
    scaled   = $signed(eps_i) >>> shift_i;
    sum_w    = SUM_W'($signed(acc_i)) + SUM_W'(scaled);
    neg      = sum_w[SUM_W-1];
    // Positive overflow: any set bit at or above the accumulator sign bit.
    over     = !neg && (|sum_w[SUM_W-2:ACC_W-1]);
    sat_hi_o = over;
    sat_lo_o = neg;
    if (over) begin
      sum_o = ACC_MAX;
    end else if (neg) begin
      sum_o = '0;
    end else begin
      sum_o = sum_w[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/agc_accumulator_mc.sv
// Multi-channel saturating AGC loop integrator: one shared adder serves
// NUM_CH accumulators; each accepted sample yields that channel's gain word
// two edges after valid_i.
module agc_accumulator_mc
  import agc_accumulator_mc_pkg::*;
#(
  parameter int              NUM_CH   = 4,
  parameter int              EPS_W    = 32,
  parameter int              ACC_W    = 32,
  parameter int              OUT_W    = 16,
  parameter logic [ACC_W-1:0] INIT_VAL = 32'h0100_0000,
  parameter int              OUT_MIN  = 1
) (
  input logic                clk,
  input logic                rst,
  agc_accumulator_mc_if.slave bus
);

  localparam int CH_W = ch_width(NUM_CH);

  function automatic logic [OUT_W-1:0] gain_map(input logic [ACC_W-1:0] a);
    logic [OUT_W-1:0] g;
    g = a[ACC_W-1 -: OUT_W];
    return (g < OUT_W'(OUT_MIN)) ? OUT_W'(OUT_MIN) : g;
  endfunction

  localparam logic [OUT_W-1:0] INIT_C = gain_map(INIT_VAL);

  // Stage 1: registered sample.
  logic               s1_vld_q;
  logic [CH_W-1:0]    s1_ch_q;
  logic [EPS_W-1:0]   s1_eps_q;
  logic [SHIFT_W-1:0] s1_shift_q;

  // Accumulators are flops so clear/reset can reload every entry at once.
  logic [ACC_W-1:0]   acc_q [NUM_CH];
  logic [ACC_W-1:0]   acc_d [NUM_CH];

  // Stage 2: registered outputs.
  logic               vld_o_q, vld_o_d;
  logic [CH_W-1:0]    ch_o_q, ch_o_d;
  logic [OUT_W-1:0]   c_o_q, c_o_d;
  logic               sat_hi_q, sat_hi_d;
  logic               sat_lo_q, sat_lo_d;
  logic               ch_err_q, ch_err_d;

  logic               ch_ok;
  logic [CH_W-1:0]    rd_idx;
  logic [ACC_W-1:0]   acc_rd;
  logic [ACC_W-1:0]   sum;
  logic               add_hi;
  logic               add_lo;

  // Select the addressed accumulator; an illegal index reads entry 0 but is
  // never written back.
  always_comb begin
    ch_ok  = ({1'b0, s1_ch_q} < (CH_W+1)'(NUM_CH));
    rd_idx = ch_ok ? s1_ch_q : '0;
    acc_rd = acc_q[rd_idx];
  end

  agc_sat_add #(
    .EPS_W (EPS_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc_i    (acc_rd),
    .eps_i    (s1_eps_q),
    .shift_i  (s1_shift_q),
    .sum_o    (sum),
    .sat_hi_o (add_hi),
    .sat_lo_o (add_lo)
  );

  // Update decision: clear beats everything, then bad channel, then freeze.
  always_comb begin
    acc_d    = acc_q;
    vld_o_d  = 1'b0;
    ch_o_d   = ch_o_q;
    c_o_d    = c_o_q;
    sat_hi_d = 1'b0;
    sat_lo_d = 1'b0;
    ch_err_d = 1'b0;
    if (bus.clear_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_d[i] = INIT_VAL;
      end
    end else if (s1_vld_q) begin
      if (!ch_ok) begin
        ch_err_d = 1'b1;
      end else begin
        vld_o_d = 1'b1;
        ch_o_d  = s1_ch_q;
        if (bus.freeze_i) begin
          c_o_d = gain_map(acc_rd);
        end else begin
          acc_d[rd_idx] = sum;
          sat_hi_d      = add_hi;
          sat_lo_d      = add_lo;
          c_o_d         = gain_map(sum);
        end
      end
    end
  end

  // Pipeline, accumulator and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_VAL) begin
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_eps_q   <= '0;
      s1_shift_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= INIT_VAL;
      end
      vld_o_q    <= 1'b0;
      ch_o_q     <= '0;
      c_o_q      <= INIT_C;
      sat_hi_q   <= 1'b0;
      sat_lo_q   <= 1'b0;
      ch_err_q   <= 1'b0;
    end else begin
      s1_vld_q <= bus.valid_i;
      if (bus.valid_i) begin
        s1_ch_q    <= bus.ch_i;
        s1_eps_q   <= bus.eps_i;
        s1_shift_q <= bus.shift_i;
      end
      acc_q    <= acc_d;
      vld_o_q  <= vld_o_d;
      ch_o_q   <= ch_o_d;
      c_o_q    <= c_o_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
      ch_err_q <= ch_err_d;
    end
  end

  assign bus.valid_o  = vld_o_q;
  assign bus.ch_o     = ch_o_q;
  assign bus.c_o      = c_o_q;
  assign bus.sat_hi_o = sat_hi_q;
  assign bus.sat_lo_o = sat_lo_q;
  assign bus.ch_err_o = ch_err_q;

endmodule

// File: tb/tb_agc_accumulator_mc.sv
// Bench for agc_accumulator_mc: directed vector table, randomized run against
// an arithmetic reference model, async-reset and bad-channel sequences.
module tb_agc_accumulator_mc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  agc_accumulator_mc_if #(.CH_W(2), .EPS_W(32), .OUT_W(16)) bus_m ();
  agc_accumulator_mc_if #(.CH_W(3), .EPS_W(32), .OUT_W(16)) bus_a ();

  agc_accumulator_mc #(.NUM_CH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  // Second instance with a non-power-of-two channel count so illegal indices
  // are representable on ch_i.
  agc_accumulator_mc #(.NUM_CH(5)) dut_aux (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam longint M_MAX  = 64'sh7FFF_FFFF;
  localparam longint M_INIT = 64'sh0100_0000;

  longint      m_acc [4];
  bit          p_v;
  int          p_ch;
  logic [31:0] p_eps;
  int          p_sh;
  bit          e_v, e_hi, e_lo;
  int          e_ch, e_c;

  function automatic int gmap(input longint a);
    int g;
    g = int'(a / 65536);
    return (g < 1) ? 1 : g;
  endfunction

  task automatic model_reset();
    foreach (m_acc[i]) m_acc[i] = M_INIT;
    p_v = 0; e_v = 0; e_hi = 0; e_lo = 0;
    e_ch = 0; e_c = gmap(M_INIT);
  endtask

  // Drive one cycle's inputs, advance the model by the update happening at
  // the coming edge, and sample the DUT 1 time unit after that edge.
  task automatic drive_cycle(input bit v, input int ch, input logic [31:0] eps,
                             input int sh, input bit frz, input bit clr);
    longint s;
    bus_m.valid_i  = v;
    bus_m.ch_i     = 2'(ch);
    bus_m.eps_i    = eps;
    bus_m.shift_i  = 4'(sh);
    bus_m.freeze_i = frz;
    bus_m.clear_i  = clr;
    e_v = 0; e_hi = 0; e_lo = 0;
    if (clr) begin
      foreach (m_acc[i]) m_acc[i] = M_INIT;
    end else if (p_v) begin
      e_v  = 1;
      e_ch = p_ch;
      if (frz) begin
        s = m_acc[p_ch];
      end else begin
        s = m_acc[p_ch] + (longint'($signed(p_eps)) >>> p_sh);
        if (s > M_MAX) begin s = M_MAX; e_hi = 1; end
        else if (s < 0) begin s = 0; e_lo = 1; end
        m_acc[p_ch] = s;
      end
      e_c = gmap(s);
    end
    p_v = v; p_ch = ch; p_eps = eps; p_sh = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid_o"},  64'(bus_m.valid_o),  64'(e_v));
    chk({tag, " c_o"},      64'(bus_m.c_o),      64'(e_c));
    chk({tag, " ch_o"},     64'(bus_m.ch_o),     64'(e_ch));
    chk({tag, " sat_hi_o"}, 64'(bus_m.sat_hi_o), 64'(e_hi));
    chk({tag, " sat_lo_o"}, 64'(bus_m.sat_lo_o), 64'(e_lo));
    chk({tag, " ch_err_o"}, 64'(bus_m.ch_err_o), 64'(0));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          v;
    int          ch;
    logic [31:0] eps;
    int          sh;
    bit          frz, clr;
    bit          ev;
    int          ech, ec;
    bit          ehi, elo;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input bit v, input int ch, input logic [31:0] eps, input int sh,
                         input bit frz, input bit clr, input bit ev, input int ech,
                         input int ec, input bit ehi, input bit elo);
    vec_t r;
    r.v = v; r.ch = ch; r.eps = eps; r.sh = sh; r.frz = frz; r.clr = clr;
    r.ev = ev; r.ech = ech; r.ec = ec; r.ehi = ehi; r.elo = elo;
    tbl.push_back(r);
  endtask

  initial begin
    logic [31:0] reps;
    int          rsel;

    bus_m.valid_i = 0; bus_m.ch_i = '0; bus_m.eps_i = '0; bus_m.shift_i = '0;
    bus_m.freeze_i = 0; bus_m.clear_i = 0;
    bus_a.valid_i = 0; bus_a.ch_i = '0; bus_a.eps_i = '0; bus_a.shift_i = '0;
    bus_a.freeze_i = 0; bus_a.clear_i = 0;
    model_reset();

    //      v ch eps           sh frz clr  ev ech ec      hi lo
    add_row(1, 2, 32'h0001_0000, 0, 0, 0,  0, 0, 16'h0100, 0, 0);
    add_row(0, 0, 32'h0,         0, 0, 0,  1, 2, 16'h0101, 0, 0);
    add_row(1, 0, 32'h7FFF_FFFF, 0, 0, 0,  0, 2, 16'h0101, 0, 0);
    add_row(1, 0, 32'h7FFF_FFFF, 0, 0, 0,  1, 0, 16'h7FFF, 1, 0);
    add_row(1, 0, 32'h8000_0000, 0, 0, 0,  1, 0, 16'h7FFF, 1, 0);
    add_row(0, 0, 32'h0,         0, 0, 0,  1, 0, 16'h0001, 0, 1);
    add_row(1, 3, 32'h0100_0000, 8, 0, 0,  0, 0, 16'h0001, 0, 0);
    add_row(1, 3, 32'hFFFF_FFFF,15, 0, 0,  1, 3, 16'h0101, 0, 0);
    add_row(1, 1, 32'h0001_0000, 0, 0, 0,  1, 3, 16'h0100, 0, 0);
    add_row(1, 1, 32'h0001_0000, 0, 0, 0,  1, 1, 16'h0101, 0, 0);
    add_row(1, 1, 32'h0001_0000, 0, 0, 0,  1, 1, 16'h0102, 0, 0);
    add_row(1, 1, 32'h0001_0000, 0, 0, 0,  1, 1, 16'h0103, 0, 0);
    add_row(0, 0, 32'h0,         0, 0, 0,  1, 1, 16'h0104, 0, 0);
    add_row(1, 2, 32'h0005_0000, 0, 0, 0,  0, 1, 16'h0104, 0, 0);
    add_row(0, 0, 32'h0,         0, 1, 0,  1, 2, 16'h0101, 0, 0);
    add_row(1, 2, 32'h0,         0, 0, 0,  0, 2, 16'h0101, 0, 0);
    add_row(0, 0, 32'h0,         0, 0, 0,  1, 2, 16'h0101, 0, 0);
    add_row(1, 3, 32'h0005_0000, 0, 0, 0,  0, 2, 16'h0101, 0, 0);
    add_row(0, 0, 32'h0,         0, 0, 1,  0, 2, 16'h0101, 0, 0);
    add_row(1, 0, 32'h0,         0, 0, 0,  0, 2, 16'h0101, 0, 0);
    add_row(1, 1, 32'h0,         0, 0, 0,  1, 0, 16'h0100, 0, 0);
    add_row(1, 2, 32'h0,         0, 0, 0,  1, 1, 16'h0100, 0, 0);
    add_row(1, 3, 32'h0,         0, 0, 0,  1, 2, 16'h0100, 0, 0);
    add_row(0, 0, 32'h0,         0, 0, 0,  1, 3, 16'h0100, 0, 0);

    // Reset state while held in reset.
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o",  64'(bus_m.valid_o),  64'(0));
    chk("reset c_o",      64'(bus_m.c_o),      64'h0100);
    chk("reset ch_o",     64'(bus_m.ch_o),     64'(0));
    chk("reset sat_hi_o", 64'(bus_m.sat_hi_o), 64'(0));
    chk("reset sat_lo_o", 64'(bus_m.sat_lo_o), 64'(0));
    chk("reset ch_err_o", 64'(bus_m.ch_err_o), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive_cycle(tbl[i].v, tbl[i].ch, tbl[i].eps, tbl[i].sh, tbl[i].frz, tbl[i].clr);
      chk($sformatf("tbl%0d valid_o", i),  64'(bus_m.valid_o),  64'(tbl[i].ev));
      chk($sformatf("tbl%0d c_o", i),      64'(bus_m.c_o),      64'(tbl[i].ec));
      chk($sformatf("tbl%0d ch_o", i),     64'(bus_m.ch_o),     64'(tbl[i].ech));
      chk($sformatf("tbl%0d sat_hi_o", i), 64'(bus_m.sat_hi_o), 64'(tbl[i].ehi));
      chk($sformatf("tbl%0d sat_lo_o", i), 64'(bus_m.sat_lo_o), 64'(tbl[i].elo));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rsel = int'($urandom_range(0, 3));
      reps = 32'($urandom);
      if (rsel == 1) reps = 32'($urandom_range(0, 32'h0004_0000));
      if (rsel == 2) reps = -32'($urandom_range(0, 32'h0004_0000));
      drive_cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), reps,
                  int'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 39) == 0);
      check_model($sformatf("rnd%0d", n));
    end

    // Async reset with a sample in flight.
    drive_cycle(0, 0, 32'h0, 0, 0, 1);
    check_model("pre_rst clr");
    drive_cycle(1, 3, 32'h0200_0000, 0, 0, 0);
    check_model("pre_rst s3");
    drive_cycle(1, 1, 32'h0010_0000, 0, 0, 0);
    check_model("pre_rst s1");
    chk("pre_rst c_o", 64'(bus_m.c_o), 64'h0300);
    bus_m.valid_i = 0;
    #1 rst = 1'b0;
    #1;
    chk("async_rst valid_o",  64'(bus_m.valid_o),  64'(0));
    chk("async_rst c_o",      64'(bus_m.c_o),      64'h0100);
    chk("async_rst ch_o",     64'(bus_m.ch_o),     64'(0));
    chk("async_rst sat_hi_o", 64'(bus_m.sat_hi_o), 64'(0));
    @(posedge clk);
    #1;
    chk("in_rst valid_o", 64'(bus_m.valid_o), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      drive_cycle(0, 0, 32'h0, 0, 0, 0);
      check_model($sformatf("post_rst%0d", n));
    end

    // Illegal channel on the 5-channel instance.
    bus_a.valid_i = 1; bus_a.ch_i = 3'd5; bus_a.eps_i = 32'h0001_0000;
    @(posedge clk); #1;
    chk("aux0 ch_err_o", 64'(bus_a.ch_err_o), 64'(0));
    chk("aux0 valid_o",  64'(bus_a.valid_o),  64'(0));
    bus_a.ch_i = 3'd4;
    @(posedge clk); #1;
    chk("aux1 ch_err_o", 64'(bus_a.ch_err_o), 64'(1));
    chk("aux1 valid_o",  64'(bus_a.valid_o),  64'(0));
    chk("aux1 c_o",      64'(bus_a.c_o),      64'h0100);
    bus_a.ch_i = 3'd7;
    @(posedge clk); #1;
    chk("aux2 ch_err_o", 64'(bus_a.ch_err_o), 64'(0));
    chk("aux2 valid_o",  64'(bus_a.valid_o),  64'(1));
    chk("aux2 ch_o",     64'(bus_a.ch_o),     64'(4));
    chk("aux2 c_o",      64'(bus_a.c_o),      64'h0101);
    bus_a.valid_i = 0;
    @(posedge clk); #1;
    chk("aux3 ch_err_o", 64'(bus_a.ch_err_o), 64'(1));
    chk("aux3 valid_o",  64'(bus_a.valid_o),  64'(0));
    chk("aux3 c_o",      64'(bus_a.c_o),      64'h0101);
    @(posedge clk); #1;
    chk("aux4 ch_err_o", 64'(bus_a.ch_err_o), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
